sram_arbiter: RTL and testbench

- Shares the single 8-bit external SRAM between two requesters: the CPU (byte read/write, ramdisk-paged) and the video fetcher (4-plane, 32-bit bursts).
- Sits directly in front of the SRAM address/data mapping block and drives its abus, ramdisk_page, memwr_n and dout inputs.
- Captures read data from that block's din output.
- Each SRAM access is a fixed-length slot; video bursts and CPU accesses are never interrupted.

---
 rtl/sram_arb_pkg.sv | 9 +
 rtl/sram_arbiter_if.sv | 30 +++
 rtl/sram_slot_timer.sv | 24 ++
 rtl/sram_arbiter.sv | 88 ++++++++
 tb/tb_sram_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM arbiter.
// Contents: FSM state enum, grant owner enum, plane/offset sizing constants.
package sram_arb_pkg;
    typedef enum logic [1:0] {IDLE, VID, CPU, DONE} state_t;
    typedef enum logic {G_CPU, G_VID} grant_t;
    localparam int NUM_PLANES = 4;
    localparam int PLANE_W    = 8;
    localparam int VID_OFS_W  = 13;
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: CPU, video and SRAM-mapping signals of the arbiter.
// slave  : arbiter side (takes requests and mem_din, drives results and mem_*).
// master : requester/memory side (drives requests and mem_din).
interface sram_arbiter_if;
    import sram_arb_pkg::*;
    logic                             cpu_req;
    logic                             cpu_wr;
    logic [15:0]                      cpu_addr;
    logic [2:0]                       cpu_page;
    logic [7:0]                       cpu_wdata;
    logic [7:0]                       cpu_rdata;
    logic                             cpu_ack;
    logic                             vid_req;
    logic [VID_OFS_W-1:0]             vid_addr;
    logic [NUM_PLANES*PLANE_W-1:0]    vid_data;
    logic                             vid_valid;
    logic [15:0]                      mem_abus;
    logic [2:0]                       mem_page;
    logic                             mem_wr_n;
    logic [7:0]                       mem_dout;
    logic [7:0]                       mem_din;
    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_page, cpu_wdata, vid_req, vid_addr, mem_din,
        output cpu_rdata, cpu_ack, vid_data, vid_valid, mem_abus, mem_page, mem_wr_n, mem_dout
    );
    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_page, cpu_wdata, vid_req, vid_addr, mem_din,
        input  cpu_rdata, cpu_ack, vid_data, vid_valid, mem_abus, mem_page, mem_wr_n, mem_dout
    );
endinterface

// File: rtl/sram_slot_timer.sv
// sram_slot_timer: counts 0..ACC_CYCLES-1 while run is high, one pass per SRAM slot.
// Ports: clk, reset_n (async active-low), run (slot in progress),
//        start (first cycle of slot), last (final cycle of slot).
module sram_slot_timer #(
    parameter int ACC_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic start,
    output logic last
);
    logic [2:0] cnt;

    assign start = run && cnt == 3'd0;
    assign last  = run && cnt == 3'(ACC_CYCLES - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else
            cnt <= (run && !last) ? cnt + 3'd1 : 3'd0;
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 8-bit SRAM between a CPU byte port and a 4-plane video fetcher.
// Ports: clk, reset_n (async active-low), bus (sram_arbiter_if.slave):
//        cpu_* byte request/response, vid_* burst request/response, mem_* mapping-block side.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int   ACC_CYCLES = 2,
    parameter logic VID_BASE   = 1'b1
) (
    input logic           clk,
    input logic           reset_n,
    sram_arbiter_if.slave bus
);
    state_t     state, state_nx;
    grant_t     last_grant, grant_nx;
    logic [1:0] plane;
    logic       wr;
    logic       slot_start, slot_last;

    sram_slot_timer #(.ACC_CYCLES(ACC_CYCLES)) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .run    (state == VID || state == CPU),
        .start  (slot_start),
        .last   (slot_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= G_CPU;
        end else begin
            state      <= state_nx;
            last_grant <= grant_nx;
        end
    end

    // On contention the side that did not win last time gets the slot.
    // The first slot of each access is address setup, so the write strobe skips it.
    always_comb begin
        state_nx      = state;
        grant_nx      = last_grant;
        bus.cpu_ack   = state == DONE && last_grant == G_CPU;
        bus.vid_valid = state == DONE && last_grant == G_VID;
        bus.mem_wr_n  = !(state == CPU && wr && !slot_start);
        case (state)
            IDLE:
                if (bus.vid_req && (!bus.cpu_req || last_grant == G_CPU)) begin
                    state_nx = VID;
                    grant_nx = G_VID;
                end else if (bus.cpu_req) begin
                    state_nx = CPU;
                    grant_nx = G_CPU;
                end
            VID:     state_nx = (slot_last && plane == 2'(NUM_PLANES - 1)) ? DONE : VID;
            CPU:     state_nx = slot_last ? DONE : CPU;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            plane         <= '0;
            wr            <= 1'b0;
            bus.mem_abus  <= '0;
            bus.mem_page  <= '0;
            bus.mem_dout  <= '0;
            bus.cpu_rdata <= '0;
            bus.vid_data  <= '0;
        end else if (state == IDLE && state_nx == VID) begin
            plane        <= '0;
            bus.mem_abus <= {VID_BASE, 2'b00, bus.vid_addr};
            bus.mem_page <= '0;
        end else if (state == IDLE && state_nx == CPU) begin
            wr           <= bus.cpu_wr;
            bus.mem_abus <= bus.cpu_addr;
            bus.mem_page <= bus.cpu_page;
            if (bus.cpu_wr)
                bus.mem_dout <= bus.cpu_wdata;
        end else if (state == VID && slot_last) begin
            bus.vid_data[PLANE_W*plane +: PLANE_W] <= bus.mem_din;
            plane                                  <= plane + 2'd1;
            bus.mem_abus[14:13]                    <= plane + 2'd1;
        end else if (state == CPU && slot_last && !wr) begin
            bus.cpu_rdata <= bus.mem_din;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter at ACC_CYCLES=2 and ACC_CYCLES=4.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic        clk = 1'b0, reset_n = 1'b0, sel4 = 1'b0;
    logic        cpu_req = 1'b0, cpu_wr = 1'b0, vid_req = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [2:0]  cpu_page = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [12:0] vid_addr = '0;
    int          tests = 0, fails = 0;

    logic [7:0]  sram [0:524287];
    bit          wrote [0:524287];
    logic [7:0]  ref_w [int];

    sram_arbiter_if b2();
    sram_arbiter_if b4();

    sram_arbiter #(.ACC_CYCLES(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(b2.slave));
    sram_arbiter #(.ACC_CYCLES(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(b4.slave));

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [18:0] a);
        case (a)
            19'h51234: return 8'hA5;
            19'h08A07: return 8'h11;
            19'h0AA07: return 8'h22;
            19'h0CA07: return 8'h33;
            19'h0EA07: return 8'h44;
            default:   return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h5A;
        endcase
    endfunction

    logic [18:0] k2, k4;
    assign k2 = {b2.mem_page, b2.mem_abus};
    assign k4 = {b4.mem_page, b4.mem_abus};
    assign b2.mem_din = wrote[k2] ? sram[k2] : init_val(k2);
    assign b4.mem_din = wrote[k4] ? sram[k4] : init_val(k4);

    always @(posedge clk) begin
        if (!b2.mem_wr_n) begin sram[k2] = b2.mem_dout; wrote[k2] = 1'b1; end
        if (!b4.mem_wr_n) begin sram[k4] = b4.mem_dout; wrote[k4] = 1'b1; end
    end

    assign b2.cpu_req = cpu_req && !sel4;
    assign b4.cpu_req = cpu_req && sel4;
    assign b2.vid_req = vid_req && !sel4;
    assign b4.vid_req = vid_req && sel4;
    assign b2.cpu_wr = cpu_wr;       assign b4.cpu_wr = cpu_wr;
    assign b2.cpu_addr = cpu_addr;   assign b4.cpu_addr = cpu_addr;
    assign b2.cpu_page = cpu_page;   assign b4.cpu_page = cpu_page;
    assign b2.cpu_wdata = cpu_wdata; assign b4.cpu_wdata = cpu_wdata;
    assign b2.vid_addr = vid_addr;   assign b4.vid_addr = vid_addr;

    logic [15:0] abus_o;
    logic [2:0]  page_o;
    logic [7:0]  dout_o, rdata_o;
    logic [31:0] vdata_o;
    logic        wr_n_o, ack_o, valid_o;
    assign abus_o  = sel4 ? b4.mem_abus  : b2.mem_abus;
    assign page_o  = sel4 ? b4.mem_page  : b2.mem_page;
    assign dout_o  = sel4 ? b4.mem_dout  : b2.mem_dout;
    assign rdata_o = sel4 ? b4.cpu_rdata : b2.cpu_rdata;
    assign vdata_o = sel4 ? b4.vid_data  : b2.vid_data;
    assign wr_n_o  = sel4 ? b4.mem_wr_n  : b2.mem_wr_n;
    assign ack_o   = sel4 ? b4.cpu_ack   : b2.cpu_ack;
    assign valid_o = sel4 ? b4.vid_valid : b2.vid_valid;

    function automatic logic [7:0] ref_rd(input logic [18:0] a);
        return ref_w.exists(int'(a)) ? ref_w[int'(a)] : init_val(a);
    endfunction

    function automatic logic [31:0] vid_ref(input logic [12:0] va);
        logic [31:0] r;
        for (int p = 0; p < 4; p++) r[8*p +: 8] = ref_rd({3'd0, 1'b1, 2'(p), va});
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    int          obs_c, obs_v, obs_low;
    logic [7:0]  obs_rd;
    logic [31:0] obs_vd;
    logic [15:0] tr_abus [1:40];
    logic [2:0]  tr_page [1:40];
    logic [7:0]  tr_dout [1:40];

    // Cycle k is the k-th cycle after the grant edge; requesters drop req on seeing their strobe.
    task automatic run_txn(input bit s4, input bit dc, input bit dv);
        @(negedge clk);
        sel4 = s4;
        obs_c = -1; obs_v = -1; obs_low = 0;
        cpu_req = dc; vid_req = dv;
        for (int k = 1; k <= 100 && (cpu_req || vid_req); k++) begin
            @(negedge clk);
            if (k <= 40) begin tr_abus[k] = abus_o; tr_page[k] = page_o; tr_dout[k] = dout_o; end
            if (!wr_n_o) obs_low++;
            if (ack_o) begin obs_c = k; obs_rd = rdata_o; cpu_req = 1'b0; end
            if (valid_o) begin obs_v = k; obs_vd = vdata_o; vid_req = 1'b0; end
        end
        if (cpu_req || vid_req) begin
            tests++; fails++;
            $display("FAIL timeout: cpu_req=%0b vid_req=%0b still pending after 100 cycles", cpu_req, vid_req);
            cpu_req = 1'b0; vid_req = 1'b0;
        end
    endtask

    typedef struct {
        bit          vid;
        bit          wr;
        logic [15:0] addr;
        logic [2:0]  page;
        logic [7:0]  wdata;
        logic [12:0] vaddr;
        int          cyc;
        logic [31:0] data;
        int          wr_low;
    } vec_t;

    vec_t tbl [3];
    bit   last_vid;
    logic [7:0] last_rd;

    initial begin
        int n, next_k, found, exp_c, exp_v, mode;
        bit dc, dv, vfirst;
        logic [31:0] ev;
        logic [7:0]  erd;
        logic [18:0] key;

        tbl[0] = '{1'b0, 1'b0, 16'h1234, 3'd5, 8'h00, 13'h0000, 3, 32'hA5, 0};
        tbl[1] = '{1'b0, 1'b1, 16'h00FF, 3'd0, 8'h3C, 13'h0000, 3, 32'hA5, 1};
        tbl[2] = '{1'b1, 1'b0, 16'h0000, 3'd0, 8'h00, 13'h0A07, 9, 32'h44332211, 0};

        repeat (3) @(negedge clk);
        chk("reset abus", abus_o, 0);
        chk("reset page", page_o, 0);
        chk("reset wr_n", wr_n_o, 1);
        chk("reset dout", dout_o, 0);
        chk("reset rdata", rdata_o, 0);
        chk("reset ack", ack_o, 0);
        chk("reset vdata", vdata_o, 0);
        chk("reset valid", valid_o, 0);

        // Both requesters held from reset: video first, then strict alternation.
        reset_n = 1'b1;
        cpu_wr = 1'b0; cpu_addr = 16'h2000; vid_addr = 13'h0A07;
        cpu_req = 1'b1; vid_req = 1'b1;
        n = 0; next_k = 9;
        for (int k = 1; k <= 60 && n < 4; k++) begin
            @(negedge clk);
            if (ack_o || valid_o) begin
                chk($sformatf("contention kind %0d", n), {31'd0, valid_o}, {31'd0, n % 2 == 0});
                chk($sformatf("contention cycle %0d", n), k, next_k);
                next_k = k + 1 + ((n % 2 == 0) ? 3 : 9);
                n++;
            end
        end
        chk("contention strobes", n, 4);
        cpu_req = 1'b0; vid_req = 1'b0;
        last_vid = 1'b0;

        for (int i = 0; i < 3; i++) begin
            cpu_wr = tbl[i].wr; cpu_addr = tbl[i].addr; cpu_page = tbl[i].page;
            cpu_wdata = tbl[i].wdata; vid_addr = tbl[i].vaddr;
            run_txn(1'b0, !tbl[i].vid, tbl[i].vid);
            chk($sformatf("vec%0d strobe cycle", i), tbl[i].vid ? obs_v : obs_c, tbl[i].cyc);
            chk($sformatf("vec%0d other strobe", i), tbl[i].vid ? obs_c : obs_v, -1);
            chk($sformatf("vec%0d data", i), tbl[i].vid ? obs_vd : {24'd0, obs_rd}, tbl[i].data);
            chk($sformatf("vec%0d wr_n low cycles", i), obs_low, tbl[i].wr_low);
            for (int k = 1; k <= (tbl[i].vid ? 8 : 2); k++) begin
                chk($sformatf("vec%0d abus c%0d", i, k), tr_abus[k],
                    tbl[i].vid ? {1'b1, 2'((k - 1) / 2), tbl[i].vaddr} : tbl[i].addr);
                chk($sformatf("vec%0d page c%0d", i, k), tr_page[k], tbl[i].vid ? 3'd0 : tbl[i].page);
                if (tbl[i].wr) chk($sformatf("vec%0d dout c%0d", i, k), tr_dout[k], tbl[i].wdata);
            end
            if (tbl[i].wr) ref_w[int'({tbl[i].page, tbl[i].addr})] = tbl[i].wdata;
        end

        // Asynchronous reset while the write strobe is active.
        @(negedge clk);
        sel4 = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'h4444; cpu_page = 3'd2; cpu_wdata = 8'h77;
        cpu_req = 1'b1;
        found = 0;
        for (int k = 1; k <= 10 && found == 0; k++) begin
            @(negedge clk);
            if (!wr_n_o) found = k;
        end
        chk("midwrite strobe cycle", found, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset wr_n", wr_n_o, 1);
        chk("midreset abus", abus_o, 0);
        chk("midreset page", page_o, 0);
        chk("midreset dout", dout_o, 0);
        chk("midreset rdata", rdata_o, 0);
        chk("midreset vdata", vdata_o, 0);
        cpu_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        repeat (8) begin @(negedge clk); if (ack_o) n++; end
        chk("ack after reset", n, 0);
        last_vid = 1'b0;
        last_rd = 8'h00;

        cpu_wr = 1'b1; cpu_addr = 16'h0100; cpu_page = 3'd1; cpu_wdata = 8'h5A;
        run_txn(1'b1, 1'b1, 1'b0);
        chk("acc4 write ack cycle", obs_c, 5);
        chk("acc4 wr_n low cycles", obs_low, 3);
        chk("acc4 write rdata", obs_rd, 0);
        ref_w[int'({3'd1, 16'h0100})] = 8'h5A;
        vid_addr = 13'h0A07;
        run_txn(1'b1, 1'b0, 1'b1);
        chk("acc4 video cycle", obs_v, 17);
        chk("acc4 video data", obs_vd, 32'h44332211);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 2);
            dc = mode != 1; dv = mode != 0;
            cpu_wr = 1'($urandom); cpu_addr = 16'($urandom); cpu_page = 3'($urandom);
            cpu_wdata = 8'($urandom); vid_addr = 13'($urandom);
            key = {cpu_page, cpu_addr};
            vfirst = dv && (!dc || !last_vid);
            exp_c = -1; exp_v = -1; ev = '0; erd = last_rd;
            if (vfirst) begin
                exp_v = 9;
                ev = vid_ref(vid_addr);
                if (dc) exp_c = 9 + 1 + 3;
            end else begin
                exp_c = 3;
                if (dv) exp_v = 3 + 1 + 9;
            end
            if (dc) begin
                if (cpu_wr) ref_w[int'(key)] = cpu_wdata;
                else erd = ref_rd(key);
            end
            if (dv && !vfirst) ev = vid_ref(vid_addr);
            run_txn(1'b0, dc, dv);
            chk($sformatf("rnd%0d cpu cycle", i), obs_c, exp_c);
            chk($sformatf("rnd%0d vid cycle", i), obs_v, exp_v);
            chk($sformatf("rnd%0d wr_n low", i), obs_low, (dc && cpu_wr) ? 1 : 0);
            if (dc) chk($sformatf("rnd%0d rdata", i), obs_rd, erd);
            if (dv) chk($sformatf("rnd%0d vdata", i), obs_vd, ev);
            if (dc) last_rd = erd;
            last_vid = (dc && dv) ? !vfirst : dv;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
